// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_arb_pkg : state type and round-robin selection for wb_rr_arbiter_4x1
// rev 1.0
// ---------------------------------------------------------------------------
package wb_arb_pkg;

  localparam int N_MASTERS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    ABORT = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } rr_pick_t;

  // First requester strictly after 'last', wrapping; 'last' itself is checked last.
  function automatic rr_pick_t rr_next(input logic [3:0] req, input logic [1:0] last);
    rr_pick_t   res;
    logic [1:0] cand;
    res = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      cand = last + 2'(i);
      if (!res.valid && req[cand]) begin
        res.valid = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_if : classic Wishbone bus bundle with master/slave views
// rev 1.0
// ---------------------------------------------------------------------------
interface wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [DW-1:0] dat_r;
  logic [DW/8-1:0] sel;
  logic          ack;
  logic          err;

  modport master (output cyc, stb, we, adr, dat_w, sel, input dat_r, ack, err);
  modport slave  (input cyc, stb, we, adr, dat_w, sel, output dat_r, ack, err);
endinterface
`default_nettype wire

// File: rtl/rr_arb_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arb_pick : combinational rotating-priority picker over four requests
// rev 1.0
// ---------------------------------------------------------------------------
module rr_arb_pick
  import wb_arb_pkg::*;
(
  input  logic [N_MASTERS-1:0] req,
  input  logic [1:0]           last,
  output logic                 valid,
  output logic [1:0]           idx
);

  rr_pick_t pick;

  assign pick  = rr_next(req, last);
  assign valid = pick.valid;
  assign idx   = pick.idx;

endmodule
`default_nettype wire

// File: rtl/wb_rr_arbiter_4x1.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_rr_arbiter_4x1 : 4:1 Wishbone round-robin arbiter with CYC lock and watchdog
// rev 1.0
// ---------------------------------------------------------------------------
module wb_rr_arbiter_4x1
  import wb_arb_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  wb_if.slave        m0,
  wb_if.slave        m1,
  wb_if.slave        m2,
  wb_if.slave        m3,
  wb_if.master       s0,
  output logic [3:0] grant,
  output logic       timeout_evt
);

  localparam int SEL_W = WB_DATA_WIDTH / 8;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int WD_W  = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [N_MASTERS-1:0]     m_cyc, m_stb, m_we, m_ack, m_err;
  logic [WB_ADDR_WIDTH-1:0] m_adr [N_MASTERS];
  logic [WB_DATA_WIDTH-1:0] m_dat [N_MASTERS];
  logic [SEL_W-1:0]         m_sel [N_MASTERS];

  arb_state_e      state;
  logic [1:0]      last_grant;
  logic [WD_W-1:0] wd_cnt;
  logic            pick_valid;
  logic [1:0]      pick_idx;
  logic            fwd, own_cyc, stall, abort_now;

  assign m_cyc = {m3.cyc, m2.cyc, m1.cyc, m0.cyc};
  assign m_stb = {m3.stb, m2.stb, m1.stb, m0.stb};
  assign m_we  = {m3.we,  m2.we,  m1.we,  m0.we};

  assign m_adr[0] = m0.adr;   assign m_adr[1] = m1.adr;
  assign m_adr[2] = m2.adr;   assign m_adr[3] = m3.adr;
  assign m_dat[0] = m0.dat_w; assign m_dat[1] = m1.dat_w;
  assign m_dat[2] = m2.dat_w; assign m_dat[3] = m3.dat_w;
  assign m_sel[0] = m0.sel;   assign m_sel[1] = m1.sel;
  assign m_sel[2] = m2.sel;   assign m_sel[3] = m3.sel;

  // Read data is broadcast; only ACK/ERR are steered to the owner.
  assign m0.dat_r = s0.dat_r; assign m1.dat_r = s0.dat_r;
  assign m2.dat_r = s0.dat_r; assign m3.dat_r = s0.dat_r;
  assign m0.ack = m_ack[0];   assign m0.err = m_err[0];
  assign m1.ack = m_ack[1];   assign m1.err = m_err[1];
  assign m2.ack = m_ack[2];   assign m2.err = m_err[2];
  assign m3.ack = m_ack[3];   assign m3.err = m_err[3];

  rr_arb_pick u_pick (
    .req   (m_cyc),
    .last  (last_grant),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // last_grant doubles as the owner index while a grant is held.
  assign fwd     = (state == OWN);
  assign own_cyc = m_cyc[last_grant];

  assign s0.cyc   = fwd & own_cyc;
  assign s0.stb   = fwd & m_stb[last_grant];
  assign s0.we    = fwd & m_we[last_grant];
  assign s0.adr   = fwd ? m_adr[last_grant] : '0;
  assign s0.dat_w = fwd ? m_dat[last_grant] : '0;
  assign s0.sel   = fwd ? m_sel[last_grant] : '0;

  assign stall     = fwd & own_cyc & m_stb[last_grant] & ~(s0.ack | s0.err);
  assign abort_now = WD_EN && stall && (wd_cnt == WD_LAST);

  always_comb begin
    m_ack = '0;
    m_err = '0;
    if (fwd) begin
      m_ack[last_grant] = s0.ack;
      m_err[last_grant] = s0.err;
    end else if (state == ABORT) begin
      m_err[last_grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= 2'd3;
      wd_cnt      <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (pick_valid) begin
            state      <= OWN;
            grant      <= 4'b0001 << pick_idx;
            last_grant <= pick_idx;
          end
        end
        OWN: begin
          if (!own_cyc) begin
            state  <= IDLE;
            grant  <= '0;
            wd_cnt <= '0;
          end else if (abort_now) begin
            state       <= ABORT;
            timeout_evt <= 1'b1;
            wd_cnt      <= '0;
          end else if (stall && WD_EN) begin
            wd_cnt <= wd_cnt + 1'b1;
          end else begin
            wd_cnt <= '0;
          end
        end
        ABORT: begin
          if (own_cyc) begin
            state <= DRAIN;
          end else begin
            state <= IDLE;
            grant <= '0;
          end
        end
        DRAIN: begin
          if (!own_cyc) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/wb_rr_arbiter_4x1.md
# wb_rr_arbiter_4x1

Four-master to one-slave Wishbone arbiter with round-robin grant, bus locking for the full CYC duration and a per-transfer watchdog. It shares a single downstream slave port, such as the subsystem's external master port or a register interconnect input, between the DMA engines and other bus masters. A hung slave is aborted with ERR rather than stalling every requester.

## Interface
Parameters:
- WB_ADDR_WIDTH, 32, address width of all five ports
- WB_DATA_WIDTH, 32, data width of all five ports
- TIMEOUT_CYCLES, 255, cycles a forwarded strobe may wait for ACK/ERR; 0 disables the watchdog

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- m0..m3  wb_if.slave  WB_ADDR/DATA_WIDTH  requester ports; m0 is first after reset
- s0  wb_if.master  WB_ADDR/DATA_WIDTH  shared downstream port
- grant  output  4  one-hot owner; 0 when idle
- timeout_evt  output  1  one-cycle pulse when a transfer is aborted

## Operation
- States:
  - IDLE: no owner.
  - OWN: granted master forwarded.
  - ABORT: ERR returned, slave released.
  - DRAIN: waits for the aborted master to drop CYC.
- IDLE:
  - Request vector = {m3.CYC..m0.CYC}.
  - If nonzero, pick the first requester searching upward from last_grant+1, modulo 4.
  - Register grant and last_grant, then go to OWN.
- OWN:
  - s0.ADR/DAT_W/SEL/WE/CYC/STB are driven combinationally from the granted master.
  - That master's ACK/ERR are driven from s0.
  - Ownership holds while the granted CYC stays high, so multi-beat block cycles are never split.
  - Granted CYC low leads to IDLE at the next edge.
- Non-granted masters: ACK=0, ERR=0; DAT_R mirrors s0.DAT_R (broadcast).
- Watchdog (TIMEOUT_CYCLES>0):
  - wd_cnt increments each OWN cycle with s0.CYC&STB high and s0.ACK|ERR low.
  - It clears on ACK/ERR, on release and in any non-OWN state.
  - When wd_cnt==TIMEOUT_CYCLES-1 and no ACK/ERR arrives that cycle, go to ABORT.
- ABORT (one cycle):
  - s0.CYC=s0.STB=0.
  - Granted master ERR=1, ACK=0.
  - timeout_evt=1.
  - Next state: DRAIN if granted CYC is still high, else IDLE.
- DRAIN: s0 idle and granted master gets no ACK/ERR; granted CYC low leads to IDLE.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1.

## Timing
- Reset values:
  - state=IDLE, grant=0, last_grant=3, wd_cnt=0, timeout_evt=0.
  - s0.CYC/STB/WE=0; s0.ADR/DAT_W/SEL=0 while idle.
  - All master ACK/ERR=0.
- Reset asserted mid-transfer:
  - Outputs take reset values from the cycle after the sampling edge.
  - Any in-flight slave response is dropped.
- Grant latency:
  - A master raising CYC in cycle 0 while IDLE is seen on s0 in cycle 1.
  - Slave ACK in cycle N reaches the master in cycle N with zero added latency.
- Handover:
  - The owner dropping CYC in cycle k gives IDLE in cycle k+1 (arbitration cycle).
  - The next owner is on s0 in cycle k+2, so one dead cycle separates owners.
- Simultaneous events:
  - ACK and terminal watchdog count in the same cycle: ACK wins, no abort.
  - Owner dropping CYC in the ACK cycle: ACK is passed, then release.
- Slave-side abort timing: ERR reaches the master exactly TIMEOUT_CYCLES cycles after s0 first sees STB for the stalled beat.
- Starvation bound: a requester waits at most 3 full ownerships plus 3 arbitration cycles.

## Structure
- Package wb_arb_pkg holds:
  - arb_state_e (IDLE, OWN, ABORT, DRAIN)
  - localparam N_MASTERS=4
  - function rr_next(req[3:0], last[1:0]) returning the index plus a valid bit.
- Sub-module rr_arb_pick: combinational rotate-priority-encoder wrapper around rr_next, so the picker is unit-testable.
- The top level holds the state register, grant/last_grant, the watchdog counter and the port muxing.

## Test plan
- Reset, then m2 raises CYC/STB with a slave ACK after 2 cycles:
  - grant=4'b0100 in cycle 1.
  - m2.ACK in cycle 3.
  - grant=0 the cycle after m2 drops CYC.
- m0..m3 all request continuously, each doing one single-beat transfer:
  - grant order 0,1,2,3,0.
  - Exactly one idle cycle between owners.
- m1 holds CYC for a 4-beat block while m0 requests:
  - m0 is not granted until m1 drops CYC.
  - All 4 ACKs go only to m1.
- TIMEOUT_CYCLES=8 with a slave that never ACKs m3:
  - m3.ERR and timeout_evt are pulsed in the cycle 8 after the strobe.
  - s0.CYC is low in that cycle.
  - The arbiter remains in DRAIN until m3 drops CYC, then grants waiting m0.
- ACK arriving on the terminal watchdog cycle (wd_cnt=7, TIMEOUT_CYCLES=8): normal ACK, no ERR, no timeout_evt.
- rst asserted while m2 owns mid-block:
  - Next cycle: grant=0 and s0.CYC=0.
  - After release, m0 wins over a simultaneous m2 request.
